tl_rx_req_sequencer: RTL and testbench

//  Sequences posted (P) and non-posted (NP) requests from the RX virtual-channel buffers to the master bridge.

---
 rtl/tl_rx_req_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_tl_rx_req_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tl_rx_req_sequencer.sv
// rtl/tl_rx_req_sequencer.sv - Sequences P/NP requests from the RX VC buffers onto the master-bridge AW/W/AR request path.
module tl_rx_req_sequencer #(
    parameter int FLAGS_WIDTH      = 6,
    parameter int PAYLOAD_LENGTH   = 10,
    parameter int VALID_DATA_WIDTH = 5,
    parameter int R_CTRL_BUS_WIDTH = 4,
    parameter int CREDIT_WIDTH     = 4
) (
    input  logic                        i_clk,
    input  logic                        i_n_rst,
    input  logic [FLAGS_WIDTH-1:0]      i_vcn_r_empty_flags,
    input  logic                        i_p_fmt_data_bit,
    input  logic [PAYLOAD_LENGTH-1:0]   i_p_length_field,
    input  logic                        i_np_fmt_data_bit,
    input  logic [PAYLOAD_LENGTH-1:0]   i_np_length_field,
    output logic [R_CTRL_BUS_WIDTH-1:0] o_r_req_ctrl,
    output logic                        o_req_valid,
    output logic                        o_req_inc,
    output logic                        o_req_data_write_inc,
    output logic                        o_req_last,
    output logic [VALID_DATA_WIDTH-1:0] o_req_valid_data,
    output logic                        o_req_class,
    input  logic                        i_AWREADY_fifo,
    input  logic                        i_WREADY_fifo,
    input  logic                        i_ARREADY_fifo,
    output logic                        o_p_ca_hdr_inc,
    output logic                        o_np_ca_hdr_inc,
    output logic                        o_p_ca_data_inc,
    output logic                        o_np_ca_data_inc,
    output logic [CREDIT_WIDTH-1:0]     o_ca_data_credits
);

    localparam int FLAG_P_HDR   = 2;
    localparam int FLAG_P_DATA  = 3;
    localparam int FLAG_NP_HDR  = 4;
    localparam int FLAG_NP_DATA = 5;

    localparam int POP_P_HDR   = 0;
    localparam int POP_P_DATA  = 1;
    localparam int POP_NP_HDR  = 2;
    localparam int POP_NP_DATA = 3;

    localparam int  BEAT_W    = PAYLOAD_LENGTH - VALID_DATA_WIDTH + 1;
    localparam logic CLASS_P  = 1'b0;
    localparam logic CLASS_NP = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW_REQ,
        S_W_DATA,
        S_AR_REQ,
        S_DROP
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic                        class_q;
    logic [PAYLOAD_LENGTH-1:0]   len_q;
    logic [BEAT_W-1:0]           beat_cnt_q;

    logic                        grant;
    logic                        grant_class;
    logic                        load_beats;
    logic                        dec_beat;
    logic [BEAT_W-1:0]           beats_total;
    logic [VALID_DATA_WIDTH-1:0] valid_data_last;
    logic                        last_beat;
    logic                        data_empty;
    logic                        unused_cpl_flags;

    logic p_hdr_avail;
    logic np_hdr_avail;

    assign p_hdr_avail      = ~i_vcn_r_empty_flags[FLAG_P_HDR];
    assign np_hdr_avail     = ~i_vcn_r_empty_flags[FLAG_NP_HDR];
    assign unused_cpl_flags = ^i_vcn_r_empty_flags[1:0];

    // Length 0 means 1024 DW; otherwise beats = ceil(len / 32).
    assign beats_total = (len_q == '0)
                       ? {1'b1, {(BEAT_W-1){1'b0}}}
                       : BEAT_W'(len_q[PAYLOAD_LENGTH-1:VALID_DATA_WIDTH])
                         + BEAT_W'(|len_q[VALID_DATA_WIDTH-1:0]);

    assign valid_data_last = len_q[VALID_DATA_WIDTH-1:0] - VALID_DATA_WIDTH'(1);
    assign last_beat       = (beat_cnt_q == BEAT_W'(1));
    assign data_empty      = (class_q == CLASS_NP) ? i_vcn_r_empty_flags[FLAG_NP_DATA]
                                                   : i_vcn_r_empty_flags[FLAG_P_DATA];

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            state_q    <= S_IDLE;
            class_q    <= CLASS_P;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                class_q <= grant_class;
                len_q   <= (grant_class == CLASS_NP) ? i_np_length_field : i_p_length_field;
            end
            if (load_beats) begin
                beat_cnt_q <= beats_total;
            end else if (dec_beat) begin
                beat_cnt_q <= beat_cnt_q - BEAT_W'(1);
            end
        end
    end

    always_comb begin
        state_d              = state_q;
        grant                = 1'b0;
        grant_class          = CLASS_P;
        load_beats           = 1'b0;
        dec_beat             = 1'b0;
        o_r_req_ctrl         = '0;
        o_req_valid          = 1'b0;
        o_req_inc            = 1'b0;
        o_req_data_write_inc = 1'b0;
        o_req_last           = 1'b0;
        o_req_valid_data     = '0;
        o_p_ca_hdr_inc       = 1'b0;
        o_np_ca_hdr_inc      = 1'b0;
        o_p_ca_data_inc      = 1'b0;
        o_np_ca_data_inc     = 1'b0;
        o_ca_data_credits    = '0;

        case (state_q)
            S_IDLE: begin
                // P has strict priority so an NP request can never pass a posted one.
                if (p_hdr_avail) begin
                    grant       = 1'b1;
                    grant_class = CLASS_P;
                    state_d     = i_p_fmt_data_bit ? S_AW_REQ : S_DROP;
                end else if (np_hdr_avail) begin
                    grant       = 1'b1;
                    grant_class = CLASS_NP;
                    state_d     = i_np_fmt_data_bit ? S_AW_REQ : S_AR_REQ;
                end
            end

            S_AW_REQ: begin
                o_req_valid = 1'b1;
                if (i_AWREADY_fifo) begin
                    o_req_inc  = 1'b1;
                    load_beats = 1'b1;
                    state_d    = S_W_DATA;
                    if (class_q == CLASS_NP) begin
                        o_r_req_ctrl[POP_NP_HDR] = 1'b1;
                        o_np_ca_hdr_inc          = 1'b1;
                    end else begin
                        o_r_req_ctrl[POP_P_HDR] = 1'b1;
                        o_p_ca_hdr_inc          = 1'b1;
                    end
                end
            end

            S_AR_REQ: begin
                o_req_valid = 1'b1;
                if (i_ARREADY_fifo) begin
                    o_req_inc                = 1'b1;
                    o_r_req_ctrl[POP_NP_HDR] = 1'b1;
                    o_np_ca_hdr_inc          = 1'b1;
                    state_d                  = S_IDLE;
                end
            end

            S_W_DATA: begin
                o_req_last       = last_beat;
                o_req_valid_data = last_beat ? valid_data_last : '1;
                // A beat moves only when the W FIFO has room and the class data buffer has a beat.
                if (i_WREADY_fifo && !data_empty) begin
                    o_req_data_write_inc = 1'b1;
                    dec_beat             = 1'b1;
                    o_ca_data_credits    = CREDIT_WIDTH'(o_req_valid_data[VALID_DATA_WIDTH-1:2])
                                         + CREDIT_WIDTH'(1);
                    if (class_q == CLASS_NP) begin
                        o_r_req_ctrl[POP_NP_DATA] = 1'b1;
                        o_np_ca_data_inc          = 1'b1;
                    end else begin
                        o_r_req_ctrl[POP_P_DATA] = 1'b1;
                        o_p_ca_data_inc          = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DROP: begin
                o_r_req_ctrl[POP_P_HDR] = 1'b1;
                o_p_ca_hdr_inc          = 1'b1;
                state_d                 = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_req_class = class_q;

endmodule

// File: tb/tb_tl_rx_req_sequencer.sv
// tb/tb_tl_rx_req_sequencer.sv - Table-driven bench for tl_rx_req_sequencer.
module tb_tl_rx_req_sequencer;

    logic       i_clk = 1'b0;
    logic       i_n_rst;
    logic [5:0] i_vcn_r_empty_flags;
    logic       i_p_fmt_data_bit;
    logic [9:0] i_p_length_field;
    logic       i_np_fmt_data_bit;
    logic [9:0] i_np_length_field;
    logic [3:0] o_r_req_ctrl;
    logic       o_req_valid;
    logic       o_req_inc;
    logic       o_req_data_write_inc;
    logic       o_req_last;
    logic [4:0] o_req_valid_data;
    logic       o_req_class;
    logic       i_AWREADY_fifo;
    logic       i_WREADY_fifo;
    logic       i_ARREADY_fifo;
    logic       o_p_ca_hdr_inc;
    logic       o_np_ca_hdr_inc;
    logic       o_p_ca_data_inc;
    logic       o_np_ca_data_inc;
    logic [3:0] o_ca_data_credits;

    typedef struct packed {
        logic [5:0] flags;
        logic       p_fmt;
        logic [9:0] p_len;
        logic       np_fmt;
        logic [9:0] np_len;
        logic       awr;
        logic       wr;
        logic       arr;
    } in_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       valid;
        logic       inc;
        logic       winc;
        logic       last;
        logic [4:0] vd;
        logic       cls;
        logic       phdr;
        logic       nphdr;
        logic       pdata;
        logic       npdata;
        logic [3:0] cr;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;
    vec_t tbl[$];

    localparam logic [5:0] E = 6'b111111;

    tl_rx_req_sequencer dut (
        .i_clk                (i_clk),
        .i_n_rst              (i_n_rst),
        .i_vcn_r_empty_flags  (i_vcn_r_empty_flags),
        .i_p_fmt_data_bit     (i_p_fmt_data_bit),
        .i_p_length_field     (i_p_length_field),
        .i_np_fmt_data_bit    (i_np_fmt_data_bit),
        .i_np_length_field    (i_np_length_field),
        .o_r_req_ctrl         (o_r_req_ctrl),
        .o_req_valid          (o_req_valid),
        .o_req_inc            (o_req_inc),
        .o_req_data_write_inc (o_req_data_write_inc),
        .o_req_last           (o_req_last),
        .o_req_valid_data     (o_req_valid_data),
        .o_req_class          (o_req_class),
        .i_AWREADY_fifo       (i_AWREADY_fifo),
        .i_WREADY_fifo        (i_WREADY_fifo),
        .i_ARREADY_fifo       (i_ARREADY_fifo),
        .o_p_ca_hdr_inc       (o_p_ca_hdr_inc),
        .o_np_ca_hdr_inc      (o_np_ca_hdr_inc),
        .o_p_ca_data_inc      (o_p_ca_data_inc),
        .o_np_ca_data_inc     (o_np_ca_data_inc),
        .o_ca_data_credits    (o_ca_data_credits)
    );

    always #5 i_clk = ~i_clk;

    function automatic in_t mk_in(logic [5:0] flags, logic p_fmt, logic [9:0] p_len,
                                  logic np_fmt, logic [9:0] np_len,
                                  logic awr, logic wr, logic arr);
        in_t v;
        v.flags = flags; v.p_fmt = p_fmt; v.p_len = p_len;
        v.np_fmt = np_fmt; v.np_len = np_len;
        v.awr = awr; v.wr = wr; v.arr = arr;
        return v;
    endfunction

    function automatic out_t mk_out(logic [3:0] ctrl, logic valid, logic inc, logic winc,
                                    logic last, logic [4:0] vd, logic cls, logic phdr,
                                    logic nphdr, logic pdata, logic npdata, logic [3:0] cr);
        out_t v;
        v.ctrl = ctrl; v.valid = valid; v.inc = inc; v.winc = winc; v.last = last;
        v.vd = vd; v.cls = cls; v.phdr = phdr; v.nphdr = nphdr;
        v.pdata = pdata; v.npdata = npdata; v.cr = cr;
        return v;
    endfunction

    function automatic out_t idle_out(logic cls);
        return mk_out(4'b0000, 0, 0, 0, 0, 5'd0, cls, 0, 0, 0, 0, 4'd0);
    endfunction

    task automatic drive(input in_t v);
        i_vcn_r_empty_flags = v.flags;
        i_p_fmt_data_bit    = v.p_fmt;
        i_p_length_field    = v.p_len;
        i_np_fmt_data_bit   = v.np_fmt;
        i_np_length_field   = v.np_len;
        i_AWREADY_fifo      = v.awr;
        i_WREADY_fifo       = v.wr;
        i_ARREADY_fifo      = v.arr;
    endtask

    // Credit amount is only meaningful alongside a data credit pulse.
    task automatic check_now(input out_t e, input string nm);
        out_t got;
        out_t exp;
        got = {o_r_req_ctrl, o_req_valid, o_req_inc, o_req_data_write_inc, o_req_last,
               o_req_valid_data, o_req_class, o_p_ca_hdr_inc, o_np_ca_hdr_inc,
               o_p_ca_data_inc, o_np_ca_data_inc, o_ca_data_credits};
        exp = e;
        if (!exp.pdata && !exp.npdata) begin
            got.cr = '0;
            exp.cr = '0;
        end
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got=%06h expected=%06h", nm, got, exp);
        end
    endtask

    task automatic step(input in_t v, input out_t e, input string nm);
        drive(v);
        #2;
        check_now(e, nm);
        @(negedge i_clk);
    endtask

    initial begin
        // P write len 70: 3 beats (31,31,5), credits 8,8,2
        tbl.push_back('{mk_in(6'b110011,1,10'd70,0,0,0,0,0), idle_out(0)});
        tbl.push_back('{mk_in(6'b110011,1,10'd70,0,0,1,0,0), mk_out(4'b0001,1,1,0,0,0,0,1,0,0,0,0)});
        tbl.push_back('{mk_in(6'b110111,1,10'd70,0,0,0,1,0), mk_out(4'b0010,0,0,1,0,31,0,0,0,1,0,8)});
        tbl.push_back('{mk_in(6'b110111,1,10'd70,0,0,0,1,0), mk_out(4'b0010,0,0,1,0,31,0,0,0,1,0,8)});
        tbl.push_back('{mk_in(6'b110111,1,10'd70,0,0,0,1,0), mk_out(4'b0010,0,0,1,1,5,0,0,0,1,0,2)});
        tbl.push_back('{mk_in(E,0,0,0,0,0,0,0), idle_out(0)});
        // NP read len 0
        tbl.push_back('{mk_in(6'b101111,0,0,0,0,0,0,0), idle_out(0)});
        tbl.push_back('{mk_in(6'b101111,0,0,0,0,0,0,1), mk_out(4'b0100,1,1,0,0,0,1,0,1,0,0,0)});
        tbl.push_back('{mk_in(E,0,0,0,0,0,0,0), idle_out(1)});
        // P and NP both present: P (len 32, one beat) first, AW held one cycle
        tbl.push_back('{mk_in(6'b100011,1,10'd32,0,0,0,0,0), idle_out(1)});
        tbl.push_back('{mk_in(6'b100011,1,10'd32,0,0,0,1,1), mk_out(4'b0000,1,0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back('{mk_in(6'b100011,1,10'd32,0,0,1,0,0), mk_out(4'b0001,1,1,0,0,0,0,1,0,0,0,0)});
        tbl.push_back('{mk_in(6'b100011,1,10'd32,0,0,0,1,0), mk_out(4'b0010,0,0,1,1,31,0,0,0,1,0,8)});
        tbl.push_back('{mk_in(6'b101111,1,10'd32,0,0,0,0,0), idle_out(0)});
        tbl.push_back('{mk_in(6'b101111,0,0,0,0,0,0,1), mk_out(4'b0100,1,1,0,0,0,1,0,1,0,0,0)});
        // P message without data -> DROP, readies ignored
        tbl.push_back('{mk_in(6'b111011,0,10'd5,0,0,0,0,0), idle_out(1)});
        tbl.push_back('{mk_in(6'b111011,0,10'd5,0,0,1,1,1), mk_out(4'b0001,0,0,0,0,0,0,1,0,0,0,0)});
        tbl.push_back('{mk_in(E,0,0,0,0,0,0,0), idle_out(0)});
        // NP write (IO/CFG) len 1
        tbl.push_back('{mk_in(6'b001111,0,0,1,10'd1,0,0,0), idle_out(0)});
        tbl.push_back('{mk_in(6'b001111,0,0,1,10'd1,1,0,0), mk_out(4'b0100,1,1,0,0,0,1,0,1,0,0,0)});
        tbl.push_back('{mk_in(6'b001111,0,0,1,10'd1,0,1,0), mk_out(4'b1000,0,0,1,1,0,1,0,0,0,1,1)});
        tbl.push_back('{mk_in(E,0,0,0,0,0,0,0), idle_out(1)});

        i_n_rst = 1'b0;
        drive(mk_in(6'b000000,1,10'd70,1,10'd3,1,1,1));
        #2;
        check_now(idle_out(0), "reset_state");
        @(negedge i_clk);
        @(negedge i_clk);
        i_n_rst = 1'b1;
        drive(mk_in(E,0,0,0,0,0,0,0));
        @(negedge i_clk);

        foreach (tbl[k]) begin
            step(tbl[k].i, tbl[k].o, $sformatf("tbl%0d", k));
        end

        // P write len 40 (2 beats): WREADY stall 3 cycles, then P data empty 2 cycles
        step(mk_in(6'b110011,1,10'd40,0,0,0,0,0), idle_out(1), "stall_idle");
        step(mk_in(6'b110011,1,10'd40,0,0,1,0,0), mk_out(4'b0001,1,1,0,0,0,0,1,0,0,0,0), "stall_aw");
        for (int s = 0; s < 3; s++) begin
            step(mk_in(6'b110111,1,10'd40,0,0,1,0,1), mk_out(4'b0000,0,0,0,0,31,0,0,0,0,0,0),
                 $sformatf("stall_wready%0d", s));
        end
        step(mk_in(6'b110111,1,10'd40,0,0,0,1,0), mk_out(4'b0010,0,0,1,0,31,0,0,0,1,0,8), "stall_beat1");
        for (int s = 0; s < 2; s++) begin
            step(mk_in(E,1,10'd40,0,0,0,1,0), mk_out(4'b0000,0,0,0,1,7,0,0,0,0,0,0),
                 $sformatf("stall_empty%0d", s));
        end
        step(mk_in(6'b110111,1,10'd40,0,0,0,1,0), mk_out(4'b0010,0,0,1,1,7,0,0,0,1,0,2), "stall_beat2");
        step(mk_in(E,0,0,0,0,0,0,0), idle_out(0), "stall_done");

        // Reset during beat 2 of a 3-beat P write
        step(mk_in(6'b110011,1,10'd70,0,0,0,0,0), idle_out(0), "rst_idle");
        step(mk_in(6'b110011,1,10'd70,0,0,1,0,0), mk_out(4'b0001,1,1,0,0,0,0,1,0,0,0,0), "rst_aw");
        step(mk_in(6'b110111,1,10'd70,0,0,0,1,0), mk_out(4'b0010,0,0,1,0,31,0,0,0,1,0,8), "rst_beat1");
        drive(mk_in(6'b110111,1,10'd70,0,0,0,1,0));
        i_n_rst = 1'b0;
        #2;
        check_now(idle_out(0), "rst_abort");
        @(negedge i_clk);
        #2;
        check_now(idle_out(0), "rst_held");
        @(negedge i_clk);
        i_n_rst = 1'b1;
        step(mk_in(E,0,0,0,0,0,0,1), idle_out(0), "rst_release");
        // Fresh P write len 33: beat counter must reload to 2
        step(mk_in(6'b110011,1,10'd33,0,0,0,0,0), idle_out(0), "rst_regrant");
        step(mk_in(6'b110011,1,10'd33,0,0,1,0,0), mk_out(4'b0001,1,1,0,0,0,0,1,0,0,0,0), "rst_aw2");
        step(mk_in(6'b110111,1,10'd33,0,0,0,1,0), mk_out(4'b0010,0,0,1,0,31,0,0,0,1,0,8), "rst_b1");
        step(mk_in(6'b110111,1,10'd33,0,0,0,1,0), mk_out(4'b0010,0,0,1,1,0,0,0,0,1,0,1), "rst_b2");
        step(mk_in(E,0,0,0,0,0,0,0), idle_out(0), "rst_end");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
